// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU control codes, ALUOp codes, ex_ctrl bit positions.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 5;

  // ALUControl codes presented to the ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b1111;
  localparam logic [3:0] ALU_SRL = 4'b1110;

  // ALUOp from the main decoder
  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  // funct3 values recognised by the ALU decoder
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // Bit positions within ex_ctrl = {reg_write, mem_read, mem_write, branch, mem_to_reg}
  localparam int unsigned CTRL_REG_WRITE  = 4;
  localparam int unsigned CTRL_MEM_READ   = 3;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_BRANCH     = 1;
  localparam int unsigned CTRL_MEM_TO_REG = 0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side fields in, EX-side fields out.
// With ID_EX_FORWARDING_EN defined the EX/MEM and MEM/WB bypass inputs are added.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [XLEN-1:0]   in_rd1;
  logic [XLEN-1:0]   in_rd2;
  logic [XLEN-1:0]   in_imm;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [1:0]        in_alu_op;
  logic              in_alu_src;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [REG_AW-1:0] in_rd;
  logic [CTRL_W-1:0] in_ctrl;

  logic              ex_valid;
  logic [XLEN-1:0]   ReadData1;
  logic [XLEN-1:0]   aluMuxResult;
  logic [3:0]        ALUControl;
  logic [XLEN-1:0]   ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_illegal;

`ifdef ID_EX_FORWARDING_EN
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd;
  logic [XLEN-1:0]   exmem_result;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic [XLEN-1:0]   memwb_result;
`endif

  modport master (
    output stall, flush, in_valid, in_rd1, in_rd2, in_imm, in_funct3, in_funct7b5,
           in_alu_op, in_alu_src, in_rs1, in_rs2, in_rd, in_ctrl,
`ifdef ID_EX_FORWARDING_EN
           exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
`endif
    input  ex_valid, ReadData1, aluMuxResult, ALUControl, ex_store_data, ex_rd, ex_ctrl, ex_illegal
  );

  modport slave (
    input  stall, flush, in_valid, in_rd1, in_rd2, in_imm, in_funct3, in_funct7b5,
           in_alu_op, in_alu_src, in_rs1, in_rs2, in_rd, in_ctrl,
`ifdef ID_EX_FORWARDING_EN
           exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
`endif
    output ex_valid, ReadData1, aluMuxResult, ALUControl, ex_store_data, ex_rd, ex_ctrl, ex_illegal
  );

endinterface

// File: rtl/alu_control_decode.sv
// Combinational ALU control decoder: (ALUOp, funct3, funct7[5]) -> ALUControl code and illegal flag.
module alu_control_decode
  import cpu_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_alu_ctrl_c,
  output logic       o_illegal_c
);

  // Unsupported combinations fall back to ADD and raise the illegal flag
  always_comb begin
    o_alu_ctrl_c = ALU_ADD;
    o_illegal_c  = 1'b0;
    case (i_alu_op)
      ALUOP_LDST:   o_alu_ctrl_c = ALU_ADD;
      ALUOP_BRANCH: o_alu_ctrl_c = ALU_SUB;
      default: begin
        // R-type and I-type share the funct3 table; only R-type uses funct7[5] to pick SUB
        case (i_funct3)
          F3_ADD: o_alu_ctrl_c = ((i_alu_op == ALUOP_RTYPE) && i_funct7b5) ? ALU_SUB : ALU_ADD;
          F3_AND: o_alu_ctrl_c = ALU_AND;
          F3_OR:  o_alu_ctrl_c = ALU_OR;
          F3_XOR: o_alu_ctrl_c = ALU_XOR;
          F3_SRL: begin
            if (!i_funct7b5) o_alu_ctrl_c = ALU_SRL;
            else             o_illegal_c  = 1'b1;
          end
          default: o_illegal_c = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: registers operands/control, decodes ALUControl, applies the ALUSrc select.
// Optional feature macro: ID_EX_FORWARDING_EN adds EX/MEM and MEM/WB operand bypass after the registers.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  logic [3:0]        w_alu_ctrl;
  logic              w_illegal;
  logic              w_bubble;
  logic [XLEN-1:0]   w_rs1_val;
  logic [XLEN-1:0]   w_rs2_val;

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_illegal;
  logic [3:0]        r_alu_ctrl;
  logic [XLEN-1:0]   r_rd1;
  logic [XLEN-1:0]   r_rd2;
  logic [XLEN-1:0]   r_imm;
  logic              r_alu_src;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;

  alu_control_decode u_alu_dec (
    .i_alu_op     (bus.in_alu_op),
    .i_funct3     (bus.in_funct3),
    .i_funct7b5   (bus.in_funct7b5),
    .o_alu_ctrl_c (w_alu_ctrl),
    .o_illegal_c  (w_illegal)
  );

  // A flush, or an unstalled load of an empty slot, inserts a bubble
  assign w_bubble = bus.flush || (!bus.stall && !bus.in_valid);

  // Stage registers: flush > stall > load; a bubble clears only valid/ctrl/illegal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_illegal  <= 1'b0;
      r_alu_ctrl <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_alu_src  <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (w_bubble) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else if (!bus.stall) begin
      r_valid    <= 1'b1;
      r_ctrl     <= bus.in_ctrl;
      r_illegal  <= w_illegal;
      r_alu_ctrl <= w_alu_ctrl;
      r_rd1      <= bus.in_rd1;
      r_rd2      <= bus.in_rd2;
      r_imm      <= bus.in_imm;
      r_alu_src  <= bus.in_alu_src;
      r_rs1      <= bus.in_rs1;
      r_rs2      <= bus.in_rs2;
      r_rd       <= bus.in_rd;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  logic w_fwd_ex_rs1, w_fwd_wb_rs1, w_fwd_ex_rs2, w_fwd_wb_rs2;

  // Bypass match: writer enabled, not x0, same index; EX/MEM is younger so it wins
  assign w_fwd_ex_rs1 = bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rs1);
  assign w_fwd_wb_rs1 = bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rs1);
  assign w_fwd_ex_rs2 = bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rs2);
  assign w_fwd_wb_rs2 = bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rs2);

  assign w_rs1_val = w_fwd_ex_rs1 ? bus.exmem_result :
                     w_fwd_wb_rs1 ? bus.memwb_result : r_rd1;
  assign w_rs2_val = w_fwd_ex_rs2 ? bus.exmem_result :
                     w_fwd_wb_rs2 ? bus.memwb_result : r_rd2;
`else
  // Without bypass the source indices are kept only for debug visibility
  logic w_unused_rs;
  assign w_unused_rs = ^{r_rs1, r_rs2};
  assign w_rs1_val   = r_rd1;
  assign w_rs2_val   = r_rd2;
`endif

  assign bus.ex_valid      = r_valid;
  assign bus.ex_ctrl       = r_ctrl;
  assign bus.ex_illegal    = r_illegal;
  assign bus.ALUControl    = r_alu_ctrl;
  assign bus.ex_rd         = r_rd;
  assign bus.ReadData1     = w_rs1_val;
  assign bus.aluMuxResult  = r_alu_src ? r_imm : w_rs2_val;
  assign bus.ex_store_data = w_rs2_val;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode table plus stall/flush/bubble/reset (and bypass) sequences.
module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        src;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  ctrl;
    logic [3:0]  e_alu;
    logic        e_ill;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_st;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                              input logic src, input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] ctrl,
                              input logic [3:0] e_alu, input logic e_ill, input logic [31:0] e_b);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.src = src;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.rd = rd; v.ctrl = ctrl;
    v.e_alu = e_alu; v.e_ill = e_ill;
    v.e_a = rd1; v.e_b = e_b; v.e_st = rd2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic src, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [4:0] ctrl);
    bus.in_valid = valid; bus.in_alu_op = op; bus.in_funct3 = f3; bus.in_funct7b5 = f7;
    bus.in_alu_src = src; bus.in_rd1 = rd1; bus.in_rd2 = rd2; bus.in_imm = imm;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd; bus.in_ctrl = ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ex_valid"},      32'(bus.ex_valid), 32'd0);
    chk({tag, " ex_ctrl"},       32'(bus.ex_ctrl), 32'd0);
    chk({tag, " ex_illegal"},    32'(bus.ex_illegal), 32'd0);
    chk({tag, " ALUControl"},    32'(bus.ALUControl), 32'd0);
    chk({tag, " ReadData1"},     bus.ReadData1, 32'd0);
    chk({tag, " aluMuxResult"},  bus.aluMuxResult, 32'd0);
    chk({tag, " ex_store_data"}, bus.ex_store_data, 32'd0);
    chk({tag, " ex_rd"},         32'(bus.ex_rd), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;

    // Decode sweep, ALUSrc and a few other ALUOp cases
    vecs[0]  = mk(2'b10, 3'b000, 1'b0, 1'b0, 32'd10,  32'd20,  32'd99, 5'd1, 5'b10000, 4'b0010, 1'b0, 32'd20);
    vecs[1]  = mk(2'b10, 3'b000, 1'b1, 1'b0, 32'd11,  32'd21,  32'd98, 5'd2, 5'b10001, 4'b0110, 1'b0, 32'd21);
    vecs[2]  = mk(2'b10, 3'b111, 1'b0, 1'b0, 32'd12,  32'd22,  32'd97, 5'd3, 5'b10000, 4'b0000, 1'b0, 32'd22);
    vecs[3]  = mk(2'b10, 3'b110, 1'b0, 1'b0, 32'd13,  32'd23,  32'd96, 5'd4, 5'b10000, 4'b0001, 1'b0, 32'd23);
    vecs[4]  = mk(2'b10, 3'b100, 1'b0, 1'b0, 32'd14,  32'd24,  32'd95, 5'd5, 5'b10000, 4'b1111, 1'b0, 32'd24);
    vecs[5]  = mk(2'b10, 3'b101, 1'b0, 1'b0, 32'd15,  32'd25,  32'd94, 5'd6, 5'b10000, 4'b1110, 1'b0, 32'd25);
    vecs[6]  = mk(2'b10, 3'b001, 1'b0, 1'b0, 32'd16,  32'd26,  32'd93, 5'd7, 5'b10000, 4'b0010, 1'b1, 32'd26);
    vecs[7]  = mk(2'b11, 3'b000, 1'b1, 1'b1, 32'd5,   32'd7,   32'hFFFFFFFD, 5'd8, 5'b10000, 4'b0010, 1'b0, 32'hFFFFFFFD);
    vecs[8]  = mk(2'b00, 3'b010, 1'b0, 1'b1, 32'h100, 32'hABC, 32'd8,  5'd9, 5'b11001, 4'b0010, 1'b0, 32'd8);
    vecs[9]  = mk(2'b01, 3'b000, 1'b0, 1'b0, 32'd40,  32'd41,  32'd12, 5'd0, 5'b00010, 4'b0110, 1'b0, 32'd41);
    vecs[10] = mk(2'b11, 3'b101, 1'b1, 1'b1, 32'd50,  32'd51,  32'd3,  5'd10, 5'b10000, 4'b0010, 1'b1, 32'd3);
    vecs[11] = mk(2'b11, 3'b111, 1'b0, 1'b1, 32'hF0F0, 32'd1,  32'h0FF, 5'd31, 5'b10000, 4'b0000, 1'b0, 32'h0FF);

    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0);
`ifdef ID_EX_FORWARDING_EN
    bus.exmem_reg_write = 1'b0; bus.exmem_rd = 5'd0; bus.exmem_result = 32'd0;
    bus.memwb_reg_write = 1'b0; bus.memwb_rd = 5'd0; bus.memwb_result = 32'd0;
`endif

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors, one instruction per cycle
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].src, vecs[i].rd1, vecs[i].rd2,
            vecs[i].imm, 5'd1, 5'd2, vecs[i].rd, vecs[i].ctrl);
      tick();
      chk($sformatf("v%0d ex_valid", i),      32'(bus.ex_valid), 32'd1);
      chk($sformatf("v%0d ALUControl", i),    32'(bus.ALUControl), 32'(vecs[i].e_alu));
      chk($sformatf("v%0d ex_illegal", i),    32'(bus.ex_illegal), 32'(vecs[i].e_ill));
      chk($sformatf("v%0d ReadData1", i),     bus.ReadData1, vecs[i].e_a);
      chk($sformatf("v%0d aluMuxResult", i),  bus.aluMuxResult, vecs[i].e_b);
      chk($sformatf("v%0d ex_store_data", i), bus.ex_store_data, vecs[i].e_st);
      chk($sformatf("v%0d ex_rd", i),         32'(bus.ex_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d ex_ctrl", i),       32'(bus.ex_ctrl), 32'(vecs[i].ctrl));
    end

    // Stall: load A, then hold for two cycles while inputs change
    @(negedge clk);
    drive(1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 32'hA1, 32'hA2, 32'hA3, 5'd1, 5'd2, 5'd12, 5'b10100);
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.stall = 1'b1;
      drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b1, 32'hB0 + 32'(k), 32'hB8, 32'hBF, 5'd3, 5'd4, 5'd13, 5'b01011);
      tick();
      chk($sformatf("stall%0d ex_valid", k),     32'(bus.ex_valid), 32'd1);
      chk($sformatf("stall%0d ALUControl", k),   32'(bus.ALUControl), 32'(4'b0001));
      chk($sformatf("stall%0d ReadData1", k),    bus.ReadData1, 32'hA1);
      chk($sformatf("stall%0d aluMuxResult", k), bus.aluMuxResult, 32'hA2);
      chk($sformatf("stall%0d ex_rd", k),        32'(bus.ex_rd), 32'd12);
      chk($sformatf("stall%0d ex_ctrl", k),      32'(bus.ex_ctrl), 32'(5'b10100));
    end

    // Stall and flush together resolve as flush; data registers keep A
    @(negedge clk);
    bus.flush = 1'b1;
    tick();
    chk("stflush ex_valid",   32'(bus.ex_valid), 32'd0);
    chk("stflush ex_ctrl",    32'(bus.ex_ctrl), 32'd0);
    chk("stflush ex_illegal", 32'(bus.ex_illegal), 32'd0);
    chk("stflush ReadData1",  bus.ReadData1, 32'hA1);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Illegal instruction loaded, then a bubble with all ctrl bits set must clear it
    drive(1'b1, 2'b10, 3'b001, 1'b0, 1'b0, 32'hC1, 32'hC2, 32'hC3, 5'd1, 5'd2, 5'd14, 5'b10000);
    tick();
    chk("illegal ex_illegal", 32'(bus.ex_illegal), 32'd1);
    @(negedge clk);
    drive(1'b0, 2'b10, 3'b001, 1'b0, 1'b0, 32'hD1, 32'hD2, 32'hD3, 5'd1, 5'd2, 5'd15, 5'b11111);
    tick();
    chk("bubble ex_valid",   32'(bus.ex_valid), 32'd0);
    chk("bubble ex_ctrl",    32'(bus.ex_ctrl), 32'd0);
    chk("bubble ex_illegal", 32'(bus.ex_illegal), 32'd0);

`ifdef ID_EX_FORWARDING_EN
    // Bypass: rs1_q=rs2_q=3, register values 0x11/0x22
    @(negedge clk);
    drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 32'h11, 32'h22, 32'h33, 5'd3, 5'd3, 5'd5, 5'b10000);
    tick();
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'hAA;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'hBB;
    #1;
    chk("fwd exmem ReadData1",     bus.ReadData1, 32'hAA);
    chk("fwd exmem ex_store_data", bus.ex_store_data, 32'hAA);
    chk("fwd exmem aluMuxResult",  bus.aluMuxResult, 32'hAA);
    bus.exmem_reg_write = 1'b0;
    #1;
    chk("fwd memwb ReadData1",     bus.ReadData1, 32'hBB);
    chk("fwd memwb ex_store_data", bus.ex_store_data, 32'hBB);
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd0;
    #1;
    chk("fwd x0 ReadData1",     bus.ReadData1, 32'h11);
    chk("fwd x0 ex_store_data", bus.ex_store_data, 32'h22);
    bus.exmem_reg_write = 1'b0; bus.memwb_reg_write = 1'b0;
`endif

    // Reset mid-run: load R-type ADD, then drop rst_n between edges
    @(negedge clk);
    drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 32'h123, 32'h456, 32'h789, 5'd1, 5'd2, 5'd9, 5'b10000);
    tick();
    chk("pre-rst ex_valid",  32'(bus.ex_valid), 32'd1);
    chk("pre-rst ReadData1", bus.ReadData1, 32'h123);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
